// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer port arbiter.
//   FB_ADDR_W / FB_DATA_W : default frame-buffer word address and pixel widths
//   pixel_t               : one RGB 4:4:4 pixel at the default width
//   gnt_t                 : which requester owns the RAM port this cycle
// -----------------------------------------------------------------------------
package fb_pkg;

   localparam int FB_ADDR_W = 15;
   localparam int FB_DATA_W = 12;

   typedef logic [FB_DATA_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_RD   = 2'd1,
      GNT_WR   = 2'd2
   } gnt_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// -----------------------------------------------------------------------------
// fb_wr_fifo
// First-word-fall-through write buffer. The head entry is always visible on
// dout while the FIFO is non-empty; pop consumes it.
//   clk, reset : clock, synchronous active-high reset (flushes the FIFO)
//   push, din  : enqueue request and payload (ignored while full)
//   pop        : dequeue the head entry (ignored while empty)
//   dout       : head entry
//   full/empty : registered status derived from the entry count
//   count      : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fb_wr_fifo #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only observable after it is written.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/fb_port_arbiter.sv
// -----------------------------------------------------------------------------
// fb_port_arbiter
// Shares the single-port frame-buffer RAM between VGA scan-out reads and
// buffered SPI pixel writes. Reads always win; writes drain from a small FIFO
// in cycles without a read.
//   clk, reset                  : pixel clock, synchronous active-high reset
//   rd_req, rd_addr             : scan-out read request and address
//   rd_valid, rd_data           : read result, one cycle after the request
//   wr_valid, wr_ready          : writer handshake
//   wr_addr, wr_data            : write payload
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata        : RAM port (read data has one-cycle latency)
//   wr_pending                  : write FIFO non-empty
//   wr_starved                  : sticky, FIFO stayed full under reads for
//                                 STARVE_LIMIT consecutive cycles
// -----------------------------------------------------------------------------
module fb_port_arbiter import fb_pkg::*; #(
   parameter int ADDR_W       = FB_ADDR_W,
   parameter int DATA_W       = FB_DATA_W,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wr_pending,
   output logic              wr_starved
);

   localparam int ENTRY_W = ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int SC_W    = $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

   gnt_t               gnt;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_head;
   logic [CNT_W-1:0]   fifo_count;

   logic               rd_pend_q, rd_pend_d;
   logic [SC_W-1:0]    starve_cnt_q, starve_cnt_d;
   logic               starved_q, starved_d;

   // Refuse pushes during reset so nothing is queued into a FIFO being flushed.
   assign wr_ready  = !fifo_full && !reset;
   assign fifo_push = wr_valid && wr_ready;
   assign fifo_pop  = (gnt == GNT_WR);

   fb_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   ({wr_addr, wr_data}),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // No grant during reset: queued writes must never reach the RAM, and a
   // read issued in the reset cycle is dropped.
   always_comb begin
      gnt = GNT_NONE;
      if (!reset) begin
         if (rd_req) begin
            gnt = GNT_RD;
         end else if (!fifo_empty) begin
            gnt = GNT_WR;
         end
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (gnt)
         GNT_RD: begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
         end
         GNT_WR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fifo_head[ENTRY_W-1:DATA_W];
            mem_wdata = fifo_head[DATA_W-1:0];
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      rd_pend_d    = (gnt == GNT_RD);
      starve_cnt_d = starve_cnt_q;
      // Any pop, or the FIFO having room, ends a starvation run.
      if (!fifo_full || fifo_pop) begin
         starve_cnt_d = '0;
      end else if (rd_req && (starve_cnt_q != STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
      starved_d = starved_q || (starve_cnt_d == STARVE_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend_q    <= 1'b0;
         starve_cnt_q <= '0;
         starved_q    <= 1'b0;
      end else begin
         rd_pend_q    <= rd_pend_d;
         starve_cnt_q <= starve_cnt_d;
         starved_q    <= starved_d;
      end
   end

   // RAM read data is already registered inside the RAM; pass it straight on.
   assign rd_valid   = rd_pend_q;
   assign rd_data    = mem_rdata;
   assign wr_pending = (fifo_count != '0);
   assign wr_starved = starved_q;

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbitrates the single-port frame-buffer RAM between the VGA scan-out reader and the SPI-side pixel writer. Scan-out reads have strict priority, so the display never misses a pixel; writes are buffered in a small FIFO and drained into the RAM during cycles with no read. The block sits between the SPI command decoder, the VGA pixel pipeline, and the frame-buffer EBR/SPRAM instance inside `top`. It runs on the 25.175 MHz pixel clock.

## Interface
- `ADDR_W`, default 15: frame-buffer word address width.
- `DATA_W`, default 12: pixel width, RGB 4:4:4.
- `FIFO_DEPTH`, default 4: write-buffer entries; power of two, at least 2.
- `STARVE_LIMIT`, default 1023: number of consecutive full-FIFO cycles that sets `wr_starved`.
- `clk` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `rd_req` in 1: scan-out requests a read this cycle.
- `rd_addr` in ADDR_W: read address.
- `rd_valid` out 1: `rd_data` is valid. Asserted exactly one cycle after the granted `rd_req`.
- `rd_data` out DATA_W: read pixel.
- `wr_valid` in 1: writer offers a pixel.
- `wr_ready` out 1: the FIFO accepts the pixel. The transfer happens when `wr_valid` and `wr_ready` are both high.
- `wr_addr` in ADDR_W, `wr_data` in DATA_W: write payload.
- `mem_en`, `mem_we` out 1: RAM enable and write enable.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: RAM address and write data.
- `mem_rdata` in DATA_W: RAM read data, with one-cycle registered latency.
- `wr_pending` out 1: the FIFO is non-empty.
- `wr_starved` out 1: sticky flag, set when the FIFO stays full for STARVE_LIMIT consecutive cycles; cleared only by `reset`.

## Operation
- Grant is decided combinationally each cycle from `rd_req` and FIFO state. There are three grant states:
  - GNT_RD: `rd_req` = 1. The read wins unconditionally.
  - GNT_WR: `rd_req` = 0 and the FIFO is non-empty. The FIFO head is written and popped.
  - GNT_NONE: no read and an empty FIFO.
- RAM port drive per grant:
  - GNT_RD: `mem_en` = 1, `mem_we` = 0, `mem_addr` = `rd_addr`.
  - GNT_WR: `mem_en` = 1, `mem_we` = 1, `mem_addr`/`mem_wdata` = FIFO head.
  - GNT_NONE: `mem_en` = 0, `mem_we` = 0, address and data hold 0.
- A registered `rd_pend` flag records GNT_RD. The next cycle, `rd_valid` = `rd_pend` and `rd_data` = `mem_rdata`, passed through unregistered.
- FIFO is first-word-fall-through with `FIFO_DEPTH` entries and `$clog2(FIFO_DEPTH)+1`-bit count.
  - `wr_ready` = !full. It is based on registered full only; no same-cycle pass-through on pop.
  - Push and pop in the same cycle leaves count unchanged; pointers wrap modulo `FIFO_DEPTH`.
  - A write to an address with a queued write is not merged; both reach the RAM in order.
- Read-after-write ordering is not enforced. A read may return the old pixel while a newer write is still queued; this is accepted (tearing of at most `FIFO_DEPTH` pixels).
- Starvation counter:
  - Increments each cycle the FIFO is full and `rd_req` = 1.
  - Resets to 0 on any pop or when not full.
  - Saturates at STARVE_LIMIT, at which point `wr_starved` is set.
- Reset mid-operation: the FIFO is flushed, and queued writes are discarded without reaching the RAM. A read granted in the reset cycle produces no `rd_valid`.

## Timing
- Reset values:
  - `rd_valid` = 0, `rd_pend` = 0.
  - `wr_ready` = 1 in the cycle after reset deasserts. It is 0 during reset.
  - `wr_pending` = 0, `wr_starved` = 0.
  - `mem_en` = 0, `mem_we` = 0, FIFO count = 0, starve counter = 0.
- Read latency: `rd_req` in cycle N gives `rd_valid`/`rd_data` in cycle N+1. Back-to-back reads give one result per cycle.
- Write latency:
  - A pixel accepted in cycle N can reach the RAM no earlier than cycle N+1.
  - With `rd_req` low, the FIFO drains one entry per cycle.
- Throughput: during the 160-pixel horizontal blanking, up to 160 writes commit per line. During active video, writes commit only if scan-out leaves gaps.
- Simultaneous events:
  - `rd_req` and a non-empty FIFO: the read wins and the FIFO holds.
  - Push while full: refused (`wr_ready` = 0); the writer must hold `wr_valid` and its payload.

## Structure
- Package `fb_pkg`: `ADDR_W`/`DATA_W` defaults, the pixel typedef, and the grant enum `gnt_t` {GNT_NONE, GNT_RD, GNT_WR}.
- Sub-module `fb_wr_fifo`: parameterised FWFT FIFO with push/pop, full/empty, and count outputs.
- The arbiter contains the grant logic, `rd_pend`, and the starvation counter.

## Test plan
- Reads only: `rd_req` high for 640 cycles with `rd_addr` 0..639 against a preloaded RAM model -> 640 `rd_valid` pulses, each one cycle later, with matching data; `mem_we` never 1.
- Writes during blanking: `rd_req` = 0, push 0x1A5 at address 0x0010 -> `mem_we` = 1 with `mem_addr` = 0x0010 and `mem_wdata` = 0x1A5 in the next cycle; `wr_pending` then falls.
- Contention: FIFO holds 4 entries, `rd_req` = 1 for 10 cycles ->
  - `wr_ready` = 0 throughout and no RAM write occurs;
  - on `rd_req` = 0, 4 writes commit on consecutive cycles, in order.
- Simultaneous push/pop: count = 2, `rd_req` = 0, push each cycle for 8 cycles -> count stays at 2 and all writes commit in FIFO order.
- Starvation: STARVE_LIMIT = 15, FIFO full, `rd_req` held high for 15 cycles -> `wr_starved` sets on cycle 15 and stays high after `rd_req` drops, until `reset`.
- Reset mid-operation: 3 entries queued plus a read granted, then `reset` for 1 cycle ->
  - no `rd_valid` in the following cycle;
  - `wr_pending` = 0, and no queued write reaches the RAM.
